// File: rtl/seven_seg_scan_decoder.sv
// Receive-side decoder for a multiplexed active-low seven-segment display; rebuilds digit values per scan frame.
// Optional macro SEVENSEG_DP_CAPTURE_EN captures the decimal point (bit 7) and includes it in the stability compare.
module seven_seg_scan_decoder #(
    parameter int NUM_DIGITS     = 4,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    CLK100MHZ,
    input  logic                    RESET_BTN,
    input  logic [7:0]              SevenSegment,
    input  logic [7:0]              SegmentDrivers,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic                    frame_valid,
    output logic                    seg_err,
    output logic                    multi_err,
    output logic                    stale
);

`ifdef SEVENSEG_DP_CAPTURE_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_CAPTURE, S_HOLD} state_t;

    // Only the anode and segment bits that matter are synchronised; the rest are ignored.
    logic unused_bits;
    assign unused_bits = ^{SevenSegment, SegmentDrivers};

    logic [NUM_DIGITS-1:0] an_meta_reg, an_sync_reg;
    logic [SEG_W-1:0]      seg_meta_reg, seg_sync_reg;

    always_ff @(posedge CLK100MHZ or posedge RESET_BTN) begin
        if (RESET_BTN) begin
            an_meta_reg  <= '1;
            an_sync_reg  <= '1;
            seg_meta_reg <= '1;
            seg_sync_reg <= '1;
        end else begin
            an_meta_reg  <= SegmentDrivers[NUM_DIGITS-1:0];
            an_sync_reg  <= an_meta_reg;
            seg_meta_reg <= SevenSegment[SEG_W-1:0];
            seg_sync_reg <= seg_meta_reg;
        end
    end

    logic [CNT_W-1:0] low_cnt;
    logic [IDX_W-1:0] drive_idx;
    logic             is_drive, is_illegal;

    always_comb begin
        low_cnt   = '0;
        drive_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_sync_reg[i]) begin
                low_cnt   = low_cnt + CNT_W'(1);
                drive_idx = IDX_W'(i);
            end
        end
    end

    assign is_drive   = (low_cnt == CNT_W'(1));
    assign is_illegal = (low_cnt > CNT_W'(1));

    state_t                state_reg;
    logic [7:0]            cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [NUM_DIGITS-1:0] prev_an_reg, hold_an_reg;
    logic [SEG_W-1:0]      prev_seg_reg, hold_seg_reg;
    logic                  same_prev, same_hold, restart, multi_set;

    assign same_prev = (an_sync_reg == prev_an_reg) && (seg_sync_reg == prev_seg_reg);
    assign same_hold = (an_sync_reg == hold_an_reg) && (seg_sync_reg == hold_seg_reg);

    // WAIT, a broken SETTLE and a changed HOLD all re-evaluate the current sample from scratch.
    always_comb begin
        restart = 1'b0;
        case (state_reg)
            S_WAIT:   restart = 1'b1;
            S_SETTLE: restart = !same_prev;
            S_HOLD:   restart = !same_hold;
            default:  restart = 1'b0;
        endcase
    end

    assign multi_set = restart && is_illegal;

    always_ff @(posedge CLK100MHZ or posedge RESET_BTN) begin
        if (RESET_BTN) begin
            state_reg    <= S_WAIT;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            prev_an_reg  <= '1;
            prev_seg_reg <= '1;
            hold_an_reg  <= '1;
            hold_seg_reg <= '1;
        end else begin
            prev_an_reg  <= an_sync_reg;
            prev_seg_reg <= seg_sync_reg;
            if (restart) begin
                if (is_drive) begin
                    state_reg <= S_SETTLE;
                    cnt_reg   <= 8'd1;
                    idx_reg   <= drive_idx;
                end else begin
                    state_reg <= S_WAIT;
                    cnt_reg   <= '0;
                end
            end else begin
                case (state_reg)
                    S_SETTLE: begin
                        if (cnt_reg == 8'(SETTLE_CYCLES - 1))
                            state_reg <= S_CAPTURE;
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                    S_CAPTURE: begin
                        state_reg    <= S_HOLD;
                        cnt_reg      <= '0;
                        hold_an_reg  <= prev_an_reg;
                        hold_seg_reg <= prev_seg_reg;
                    end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [3:0] decode_seg(input logic [6:0] s);
        case (s)
            7'h40:   decode_seg = 4'h0;
            7'h79:   decode_seg = 4'h1;
            7'h24:   decode_seg = 4'h2;
            7'h30:   decode_seg = 4'h3;
            7'h19:   decode_seg = 4'h4;
            7'h12:   decode_seg = 4'h5;
            7'h02:   decode_seg = 4'h6;
            7'h78:   decode_seg = 4'h7;
            7'h00:   decode_seg = 4'h8;
            7'h10:   decode_seg = 4'h9;
            7'h7F:   decode_seg = 4'hA;
            default: decode_seg = 4'hF;
        endcase
    endfunction

    logic [3:0]            dec_val;
    logic                  capture;
    logic [3:0]            staging_reg  [NUM_DIGITS];
    logic [3:0]            staging_next [NUM_DIGITS];
    logic [3:0]            digits_reg   [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] mask_reg, mask_next;
    logic [TO_W-1:0]       tcnt_reg;
    logic                  frame_valid_reg, seg_err_reg, multi_err_reg, stale_reg;

    // The settled sample is still in prev_* during the CAPTURE cycle.
    assign dec_val = decode_seg(prev_seg_reg[6:0]);
    assign capture = (state_reg == S_CAPTURE);

    always_comb begin
        staging_next          = staging_reg;
        staging_next[idx_reg] = dec_val;
        mask_next             = mask_reg | (NUM_DIGITS'(1) << idx_reg);
    end

    always_ff @(posedge CLK100MHZ or posedge RESET_BTN) begin
        if (RESET_BTN) begin
            staging_reg     <= '{default: '0};
            digits_reg      <= '{default: '0};
            mask_reg        <= '0;
            tcnt_reg        <= '0;
            frame_valid_reg <= 1'b0;
            seg_err_reg     <= 1'b0;
            multi_err_reg   <= 1'b0;
            stale_reg       <= 1'b0;
        end else begin
            frame_valid_reg <= 1'b0;
            if (capture) begin
                staging_reg <= staging_next;
                tcnt_reg    <= '0;
                stale_reg   <= 1'b0;
                if (&mask_next) begin
                    digits_reg      <= staging_next;
                    frame_valid_reg <= 1'b1;
                    mask_reg        <= '0;
                end else begin
                    mask_reg <= mask_next;
                end
            end else if (tcnt_reg != TO_W'(TIMEOUT_CYCLES)) begin
                tcnt_reg  <= tcnt_reg + TO_W'(1);
                stale_reg <= (tcnt_reg + TO_W'(1) == TO_W'(TIMEOUT_CYCLES));
            end

            if (capture && dec_val == 4'hF)
                seg_err_reg <= 1'b1;
            else if (err_clr)
                seg_err_reg <= 1'b0;

            if (multi_set)
                multi_err_reg <= 1'b1;
            else if (err_clr)
                multi_err_reg <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digits
            assign digits[4*gi+3:4*gi] = digits_reg[gi];
        end
    endgenerate

`ifdef SEVENSEG_DP_CAPTURE_EN
    logic [NUM_DIGITS-1:0] dp_stage_reg, dp_stage_next, dp_out_reg;

    always_comb begin
        dp_stage_next          = dp_stage_reg;
        dp_stage_next[idx_reg] = ~prev_seg_reg[7];
    end

    always_ff @(posedge CLK100MHZ or posedge RESET_BTN) begin
        if (RESET_BTN) begin
            dp_stage_reg <= '0;
            dp_out_reg   <= '0;
        end else if (capture) begin
            dp_stage_reg <= dp_stage_next;
            if (&mask_next)
                dp_out_reg <= dp_stage_next;
        end
    end

    assign dp_out = dp_out_reg;
`else
    assign dp_out = '0;
`endif

    assign frame_valid = frame_valid_reg;
    assign seg_err     = seg_err_reg;
    assign multi_err   = multi_err_reg;
    assign stale       = stale_reg;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder: scans digit patterns and checks frames, errors and timeout.
module tb_seven_seg_scan_decoder;

    localparam int ND = 4;
    localparam int TO = 300;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    seg_in, an_in;
    logic          err_clr;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] dp_out;
    logic          frame_valid, seg_err, multi_err, stale;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    int frames_base;
    logic [15:0] last_digits = '0;
    logic [3:0]  last_dp = '0;

    seven_seg_scan_decoder #(
        .NUM_DIGITS(ND),
        .SETTLE_CYCLES(16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK100MHZ(clk),
        .RESET_BTN(rst),
        .SevenSegment(seg_in),
        .SegmentDrivers(an_in),
        .err_clr(err_clr),
        .digits(digits),
        .dp_out(dp_out),
        .frame_valid(frame_valid),
        .seg_err(seg_err),
        .multi_err(multi_err),
        .stale(stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) begin
            frames      = frames + 1;
            last_digits = digits;
            last_dp     = dp_out;
            $display("frame %0d digits=%h dp=%b", frames, digits, dp_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("check %s ok value=%0h", tag, got);
        end
    endtask

    // Called on a negedge; holds the bus values for n clock cycles.
    task automatic dwell(input logic [7:0] an, input logic [7:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        seg_in  = 8'hFF;
        an_in   = 8'hFF;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_dp", 32'(dp_out), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_seg_err", 32'(seg_err), 32'h0);
        check("rst_multi_err", 32'(multi_err), 32'h0);
        check("rst_stale", 32'(stale), 32'h0);

        repeat (290) @(negedge clk);
        check("stale_before_timeout", 32'(stale), 32'h0);
        repeat (20) @(negedge clk);
        check("stale_after_timeout", 32'(stale), 32'h1);

        // Basic scan; bit 7 high on digits 0 and 2 means dp off there.
        frames_base = frames;
        dwell(8'hFE, 8'hF9, 20);
        dwell(8'hFD, 8'h24, 20);
        dwell(8'hFB, 8'hB0, 20);
        dwell(8'hF7, 8'h19, 20);
        dwell(8'hFF, 8'hFF, 5);
        check("scan_frames", 32'(frames - frames_base), 32'd1);
        check("scan_digits", 32'(last_digits), 32'h4321);
`ifdef SEVENSEG_DP_CAPTURE_EN
        check("scan_dp", 32'(last_dp), 32'hA);
`else
        check("scan_dp", 32'(last_dp), 32'h0);
`endif
        check("scan_seg_err", 32'(seg_err), 32'h0);
        check("scan_multi_err", 32'(multi_err), 32'h0);
        check("scan_stale", 32'(stale), 32'h0);

        // Short dwell on digit 2 must not count towards the frame.
        frames_base = frames;
        dwell(8'hFB, 8'h02, 14);
        dwell(8'hFE, 8'h78, 20);
        dwell(8'hFD, 8'h00, 20);
        dwell(8'hF7, 8'h10, 20);
        dwell(8'hFF, 8'hFF, 5);
        check("short_no_frame", 32'(frames - frames_base), 32'd0);
        dwell(8'hFB, 8'h12, 20);
        dwell(8'hFF, 8'hFF, 5);
        check("short_frames", 32'(frames - frames_base), 32'd1);
        check("short_digits", 32'(last_digits), 32'h9587);

        // Two anodes low.
        frames_base = frames;
        dwell(8'hF5, 8'h40, 20);
        dwell(8'hFF, 8'hFF, 3);
        check("multi_no_frame", 32'(frames - frames_base), 32'd0);
        check("multi_err_set", 32'(multi_err), 32'h1);
        dwell(8'hFF, 8'hFF, 3);
        check("multi_err_sticky", 32'(multi_err), 32'h1);
        pulse_clr();
        check("multi_err_clr", 32'(multi_err), 32'h0);

        // Unrecognised segment pattern on digit 0.
        dwell(8'hFE, 8'h55, 20);
        dwell(8'hFD, 8'h40, 20);
        dwell(8'hFB, 8'h79, 20);
        dwell(8'hF7, 8'h24, 20);
        dwell(8'hFF, 8'hFF, 5);
        check("segerr_flag", 32'(seg_err), 32'h1);
        check("segerr_nibble", 32'(last_digits[3:0]), 32'hF);
        check("segerr_digits", 32'(last_digits), 32'h210F);
        pulse_clr();
        check("segerr_clr", 32'(seg_err), 32'h0);

        // Reset in the middle of a frame discards the three staged digits.
        frames_base = frames;
        dwell(8'hFE, 8'h19, 20);
        dwell(8'hFD, 8'h19, 20);
        dwell(8'hFB, 8'h19, 20);
        an_in  = 8'hFF;
        seg_in = 8'hFF;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("midrst_digits", 32'(digits), 32'h0);
        dwell(8'hF7, 8'h24, 20);
        dwell(8'hFF, 8'hFF, 5);
        check("midrst_no_frame", 32'(frames - frames_base), 32'd0);
        dwell(8'hFE, 8'h40, 20);
        dwell(8'hFD, 8'hF9, 20);
        dwell(8'hFB, 8'h40, 20);
        dwell(8'hFF, 8'hFF, 5);
        check("midrst_frames", 32'(frames - frames_base), 32'd1);
        check("midrst_digits_new", 32'(last_digits), 32'h2010);
`ifdef SEVENSEG_DP_CAPTURE_EN
        check("midrst_dp", 32'(last_dp), 32'hD);
`else
        check("midrst_dp", 32'(last_dp), 32'h0);
`endif

        repeat (TO + 10) @(negedge clk);
        check("stale_end", 32'(stale), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
